// File: rtl/mouse_pkg.sv
// Shared PS/2 mouse definitions: receiver state encoding, error-code layout, timeout default.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mouse_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_DATA   = 3'd1,
    RX_PARITY = 3'd2,
    RX_STOP   = 3'd3,
    RX_DONE   = 3'd4
  } rx_state_t;

  // Bit positions inside BYTE_ERROR_CODE
  localparam int ERR_PARITY_BIT = 0;
  localparam int ERR_STOP_BIT   = 1;

  // 0.5 ms of silence on the mouse clock at 100 MHz aborts a frame
  localparam int MOUSE_TIMEOUT_CYCLES = 50000;

  // Odd-parity bit that makes the total number of ones (data + parity) odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/mouse_receiver.sv
// PS/2 mouse byte receiver: samples data on mouse-clock falling edges, checks parity and stop bit.
// Latency: BYTE_READY pulses 2 CLK cycles after the cycle that sees the stop-bit falling edge.
// Backpressure: none; receive-only, READ_ENABLE gates only new start bits, a frame stalled past TIMEOUT_CYCLES is dropped.
module mouse_receiver
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MOUSE_TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_t      state, next_state;
  logic           clk_mouse_dly;
  logic           fe;
  logic           start;
  logic           timed_out;
  logic [2:0]     bit_cnt;
  logic [TW-1:0]  timeout_cnt;
  logic [7:0]     shift_reg;
  logic           parity_err;
  logic           stop_err;

  // Delayed copy of the mouse clock; kept running through reset so the first edge after release is seen
  always_ff @(posedge CLK) begin
    clk_mouse_dly <= CLK_MOUSE_IN;
  end

  assign fe        = clk_mouse_dly & ~CLK_MOUSE_IN;
  assign start     = fe & READ_ENABLE & ~DATA_MOUSE_IN;
  assign timed_out = (timeout_cnt >= TW'(TIMEOUT_CYCLES));

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= RX_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; a stalled frame aborts before a coincident edge is honoured
  always_comb begin
    next_state = state;
    unique case (state)
      RX_IDLE:   if (start) next_state = RX_DATA;
      RX_DATA: begin
        if (timed_out)                   next_state = RX_IDLE;
        else if (fe && bit_cnt == 3'd7)  next_state = RX_PARITY;
      end
      RX_PARITY: begin
        if (timed_out) next_state = RX_IDLE;
        else if (fe)   next_state = RX_STOP;
      end
      RX_STOP: begin
        if (timed_out) next_state = RX_IDLE;
        else if (fe)   next_state = RX_DONE;
      end
      RX_DONE:   next_state = RX_IDLE;
      default:   next_state = RX_IDLE;
    endcase
  end

  // Bit capture, error flags and the inter-edge timeout counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt     <= '0;
      timeout_cnt <= '0;
      shift_reg   <= '0;
      parity_err  <= 1'b0;
      stop_err    <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (start) begin
            bit_cnt     <= '0;
            timeout_cnt <= '0;
          end
        end
        RX_DATA, RX_PARITY, RX_STOP: begin
          if (fe) timeout_cnt <= '0;
          else    timeout_cnt <= timeout_cnt + 1'b1;
          if (fe && !timed_out) begin
            if (state == RX_DATA) begin
              shift_reg[bit_cnt] <= DATA_MOUSE_IN;
              bit_cnt            <= bit_cnt + 3'd1;
            end
            if (state == RX_PARITY) parity_err <= (DATA_MOUSE_IN != odd_parity(shift_reg));
            if (state == RX_STOP)   stop_err   <= ~DATA_MOUSE_IN;
          end
        end
        default: ;
      endcase
    end
  end

  // Output registers: loaded once per completed frame, held otherwise
  always_ff @(posedge CLK) begin
    if (RESET) begin
      BYTE_READ       <= '0;
      BYTE_ERROR_CODE <= '0;
      BYTE_READY      <= 1'b0;
    end else begin
      BYTE_READY <= (state == RX_DONE);
      if (state == RX_DONE) begin
        BYTE_READ                       <= shift_reg;
        BYTE_ERROR_CODE[ERR_PARITY_BIT] <= parity_err;
        BYTE_ERROR_CODE[ERR_STOP_BIT]   <= stop_err;
      end
    end
  end

endmodule
